// File: rtl/qam32_symbol_mapper.sv
// 32-QAM cross-constellation Tx mapper: packs bytes MSB-first into 5-bit symbols and maps to signed Re/Im.
// Optional build macro QAM_MOD_SYM_COUNT_EN adds the SymCount per-frame handoff counter output.
module qam32_symbol_mapper #(
   parameter int AMP_UNIT = 458,
   parameter int DATA_W   = 24
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     TxDataValid,
   input  logic [7:0]               TxData,
   input  logic                     TxDataLast,
   output logic                     TxDataReady,
   output logic                     QAMModValid,
   output logic signed [DATA_W-1:0] QAMModRe,
   output logic signed [DATA_W-1:0] QAMModIm,
   output logic                     QAMModLast,
   input  logic                     QAMModReady
`ifdef QAM_MOD_SYM_COUNT_EN
   ,
   output logic [15:0]              SymCount
`endif
);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state;
   logic [11:0] acc;
   logic [3:0]  count;
   logic        pop;
   logic        accept;
   logic        flush_last;
   logic [11:0] acc_base;
   logic [3:0]  count_base;
   logic [11:0] insert;
   logic [7:0]  levels;

   // Returns {re, im} as signed odd multiples of AMP_UNIT (-5..+5) packed in two nibbles.
   function automatic logic [7:0] sym_levels(input logic [4:0] s);
      case (s)
         5'd0:  return 8'hD5;  5'd1:  return 8'hF5;  5'd2:  return 8'hDB;  5'd3:  return 8'hFB;
         5'd4:  return 8'hB3;  5'd5:  return 8'hB1;  5'd6:  return 8'hBD;  5'd7:  return 8'hBF;
         5'd8:  return 8'hF3;  5'd9:  return 8'hF1;  5'd10: return 8'hFD;  5'd11: return 8'hFF;
         5'd12: return 8'hD3;  5'd13: return 8'hD1;  5'd14: return 8'hDD;  5'd15: return 8'hDF;
         5'd16: return 8'h35;  5'd17: return 8'h15;  5'd18: return 8'h3B;  5'd19: return 8'h1B;
         5'd20: return 8'h53;  5'd21: return 8'h51;  5'd22: return 8'h5D;  5'd23: return 8'h5F;
         5'd24: return 8'h13;  5'd25: return 8'h11;  5'd26: return 8'h1D;  5'd27: return 8'h1F;
         5'd28: return 8'h33;  5'd29: return 8'h31;  5'd30: return 8'h3D;  default: return 8'h3F;
      endcase
   endfunction

   function automatic logic signed [DATA_W-1:0] scale(input logic [3:0] lvl);
      int v;
      v = int'($signed(lvl)) * AMP_UNIT;
      return DATA_W'(v);
   endfunction

   // Valid bits sit left-aligned in acc (oldest at bit 11); unused low bits are always zero,
   // which makes the FLUSH padding free.
   always_comb begin
      pop         = ((count >= 4'd5) || (state == FLUSH && count != 4'd0)) &&
                    (!QAMModValid || QAMModReady);
      TxDataReady = !Rst && (state == RUN) &&
                    ((count <= 4'd4) || ((count <= 4'd9) && pop));
      accept      = TxDataValid && TxDataReady;
      flush_last  = (state == FLUSH) && (count <= 4'd5);
      acc_base    = pop ? {acc[6:0], 5'b00000} : acc;
      count_base  = pop ? ((count >= 4'd5) ? count - 4'd5 : 4'd0) : count;
      insert      = {TxData, 4'h0} >> count_base;
      levels      = sym_levels(acc[11:7]);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= RUN;
         acc         <= '0;
         count       <= '0;
         QAMModValid <= 1'b0;
         QAMModRe    <= '0;
         QAMModIm    <= '0;
         QAMModLast  <= 1'b0;
      end else begin
         acc   <= accept ? (acc_base | insert) : acc_base;
         count <= accept ? count_base + 4'd8 : count_base;

         if (accept && TxDataLast)
            state <= FLUSH;
         else if (pop && flush_last)
            state <= RUN;

         if (pop) begin
            QAMModValid <= 1'b1;
            QAMModRe    <= scale(levels[7:4]);
            QAMModIm    <= scale(levels[3:0]);
            QAMModLast  <= flush_last;
         end else if (QAMModReady) begin
            QAMModValid <= 1'b0;
         end
      end
   end

`ifdef QAM_MOD_SYM_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Rst)
         SymCount <= '0;
      else if (QAMModValid && QAMModReady)
         SymCount <= QAMModLast ? 16'd0 : SymCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_qam32_symbol_mapper.sv
// Directed self-checking bench for qam32_symbol_mapper (SymCount checks under QAM_MOD_SYM_COUNT_EN).
module tb_qam32_symbol_mapper;

   localparam int DATA_W = 24;

   logic                     Clk = 1'b0;
   logic                     Rst;
   logic                     TxDataValid;
   logic [7:0]               TxData;
   logic                     TxDataLast;
   logic                     TxDataReady;
   logic                     QAMModValid;
   logic signed [DATA_W-1:0] QAMModRe;
   logic signed [DATA_W-1:0] QAMModIm;
   logic                     QAMModLast;
   logic                     QAMModReady;
`ifdef QAM_MOD_SYM_COUNT_EN
   logic [15:0]              SymCount;
`endif

   int checks   = 0;
   int failures = 0;

   int q_re[$];
   int q_im[$];
   int q_last[$];
   int q_cnt[$];
   int e_re[$];
   int e_im[$];
   int e_last[$];

   always #5 Clk = ~Clk;

   qam32_symbol_mapper dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .TxDataValid (TxDataValid),
      .TxData      (TxData),
      .TxDataLast  (TxDataLast),
      .TxDataReady (TxDataReady),
      .QAMModValid (QAMModValid),
      .QAMModRe    (QAMModRe),
      .QAMModIm    (QAMModIm),
      .QAMModLast  (QAMModLast),
      .QAMModReady (QAMModReady)
`ifdef QAM_MOD_SYM_COUNT_EN
      ,
      .SymCount    (SymCount)
`endif
   );

   // Record every handed-off symbol away from the active edge.
   always @(negedge Clk) begin
      if (Rst === 1'b0 && QAMModValid === 1'b1 && QAMModReady === 1'b1) begin
         q_re.push_back(int'(QAMModRe));
         q_im.push_back(int'(QAMModIm));
         q_last.push_back(int'(QAMModLast));
`ifdef QAM_MOD_SYM_COUNT_EN
         q_cnt.push_back(int'(SymCount));
`endif
      end
   end

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic last);
      int n;
      n = 0;
      TxDataValid = 1'b1;
      TxData      = b;
      TxDataLast  = last;
      forever begin
         @(negedge Clk);
         if (TxDataReady === 1'b1) break;
         n++;
         if (n > 300) begin
            checkOutput("byte_accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge Clk);
      #1;
      TxDataValid = 1'b0;
      TxDataLast  = 1'b0;
   endtask

   task automatic expectSym(input int re, input int im, input int last);
      e_re.push_back(re);
      e_im.push_back(im);
      e_last.push_back(last);
   endtask

   task automatic verifySymbols(input string tag);
      int n;
      n = e_re.size();
      for (int c = 0; c < 300 && q_re.size() < n; c++) begin
         @(posedge Clk);
         #1;
      end
      checkOutput($sformatf("%s_count", tag), q_re.size(), n);
      for (int i = 0; i < n && i < q_re.size(); i++) begin
         checkOutput($sformatf("%s_re%0d", tag, i), q_re[i], e_re[i]);
         checkOutput($sformatf("%s_im%0d", tag, i), q_im[i], e_im[i]);
         checkOutput($sformatf("%s_last%0d", tag, i), q_last[i], e_last[i]);
      end
      q_re.delete(); q_im.delete(); q_last.delete(); q_cnt.delete();
      e_re.delete(); e_im.delete(); e_last.delete();
   endtask

   task automatic expectFrameZeroToSeven();
      expectSym(-1374,  2290, 0);
      expectSym( -458,  2290, 0);
      expectSym(-1374, -2290, 0);
      expectSym( -458, -2290, 0);
      expectSym(-2290,  1374, 0);
      expectSym(-2290,   458, 0);
      expectSym(-2290, -1374, 0);
      expectSym(-2290,  -458, 1);
   endtask

   task automatic sendFrameZeroToSeven();
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h44, 1'b0);
      applyStimulus(8'h32, 1'b0);
      applyStimulus(8'h14, 1'b0);
      applyStimulus(8'hC7, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int held_re, held_im, held_last;
      Rst         = 1'b1;
      TxDataValid = 1'b1;
      TxData      = 8'hA5;
      TxDataLast  = 1'b0;
      QAMModReady = 1'b1;

      repeat (3) begin
         @(posedge Clk);
         #1;
         checkOutput("rst_txready", TxDataReady, 0);
         checkOutput("rst_valid", QAMModValid, 0);
         checkOutput("rst_re", QAMModRe, 0);
         checkOutput("rst_im", QAMModIm, 0);
      end
      Rst         = 1'b0;
      TxDataValid = 1'b0;

      expectFrameZeroToSeven();
      sendFrameZeroToSeven();
`ifdef QAM_MOD_SYM_COUNT_EN
      for (int c = 0; c < 300 && q_re.size() < 8; c++) begin
         @(posedge Clk);
         #1;
      end
      for (int i = 0; i < q_cnt.size(); i++)
         checkOutput($sformatf("symcount%0d", i), q_cnt[i], i);
      @(posedge Clk);
      #1;
      checkOutput("symcount_after_last", SymCount, 0);
`endif
      verifySymbols("frame1");

      expectSym(1374, -458, 0);
      expectSym(1374, 1374, 1);
      applyStimulus(8'hFF, 1'b1);
      verifySymbols("single_ff");

      QAMModReady = 1'b0;
      expectFrameZeroToSeven();
      fork
         sendFrameZeroToSeven();
         begin
            for (int c = 0; c < 50 && QAMModValid !== 1'b1; c++)
               @(negedge Clk);
            checkOutput("stall_valid", QAMModValid, 1);
            held_re   = int'(QAMModRe);
            held_im   = int'(QAMModIm);
            held_last = int'(QAMModLast);
            repeat (10) begin
               @(negedge Clk);
               checkOutput("stall_hold_re", QAMModRe, held_re);
               checkOutput("stall_hold_im", QAMModIm, held_im);
               checkOutput("stall_hold_last", QAMModLast, held_last);
            end
            checkOutput("stall_txready", TxDataReady, 0);
            @(posedge Clk);
            #1;
            QAMModReady = 1'b1;
         end
      join
      verifySymbols("stall");

      expectSym(-1374, 2290, 0);
      applyStimulus(8'h00, 1'b0);
      repeat (20) @(posedge Clk);
      #1;
      verifySymbols("no_last");
      checkOutput("no_last_idle", QAMModValid, 0);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;

      QAMModReady = 1'b0;
      applyStimulus(8'hFF, 1'b1);
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("flush_held_valid", QAMModValid, 1);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("flush_rst_valid", QAMModValid, 0);
      checkOutput("flush_rst_re", QAMModRe, 0);
      checkOutput("flush_rst_last", QAMModLast, 0);
      Rst         = 1'b0;
      QAMModReady = 1'b1;
      q_re.delete(); q_im.delete(); q_last.delete(); q_cnt.delete();
      expectSym(1374, -458, 0);
      expectSym(1374, 1374, 1);
      applyStimulus(8'hFF, 1'b1);
      verifySymbols("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
